// File: rtl/ansi_pkg.sv
// rtl/ansi_pkg.sv - key kinds, byte constants and state encoding for the ANSI key decoder
package ansi_pkg;

    typedef enum logic [2:0] {
        KIND_ASCII     = 3'd0,
        KIND_UP        = 3'd1,
        KIND_DOWN      = 3'd2,
        KIND_RIGHT     = 3'd3,
        KIND_LEFT      = 3'd4,
        KIND_ESC       = 3'd5,
        KIND_META      = 3'd6,
        KIND_CSI_OTHER = 3'd7
    } key_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ESC  = 2'd1,
        ST_SS3  = 2'd2,
        ST_CSI  = 2'd3
    } state_t;

    localparam logic [7:0] BYTE_ESC = 8'h1B;
    localparam logic [7:0] BYTE_CSI = 8'h5B;
    localparam logic [7:0] BYTE_SS3 = 8'h4F;
    localparam logic [7:0] BYTE_SEP = 8'h3B;
    localparam logic [7:0] BYTE_CPR = 8'h52;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic is_final(input logic [7:0] b);
        return (b >= 8'h40) && (b <= 8'h7E);
    endfunction

    function automatic logic is_arrow(input logic [7:0] b);
        return (b >= 8'h41) && (b <= 8'h44);
    endfunction

    // 'A'..'D' carry 1..4 in their low bits, which is exactly UP..LEFT
    function automatic key_kind_t arrow_kind(input logic [2:0] low);
        return key_kind_t'(low);
    endfunction

endpackage

// File: rtl/ansi_key_decoder_if.sv
// rtl/ansi_key_decoder_if.sv - receive byte strobe in, decoded key event out
interface ansi_key_decoder_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       key_valid;
    logic [2:0] key_kind;
    logic [7:0] key_code;
    logic [7:0] csi_p0;
    logic [7:0] csi_p1;

    modport master (
        output rx_valid, rx_data,
        input  key_valid, key_kind, key_code, csi_p0, csi_p1
    );

    modport slave (
        input  rx_valid, rx_data,
        output key_valid, key_kind, key_code, csi_p0, csi_p1
    );
endinterface

// File: rtl/dec_accum.sv
// rtl/dec_accum.sv - 8-bit saturating decimal accumulator
module dec_accum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic [7:0] value
);
    logic [11:0] next_val;

    // 255*10+9 fits in 12 bits, so saturation is a single compare
    assign next_val = ({4'd0, value} * 12'd10) + {8'd0, digit};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= 8'd0;
        end else if (digit_valid) begin
            value <= (next_val > 12'd255) ? 8'hFF : next_val[7:0];
        end
    end
endmodule

// File: rtl/ansi_key_decoder.sv
// rtl/ansi_key_decoder.sv - decodes UART bytes into ASCII, ESC, META, SS3 and CSI key events
module ansi_key_decoder
    import ansi_pkg::*;
#(
    parameter int ESC_TIMEOUT = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic                clk,
    input  logic                rst,
    ansi_key_decoder_if.slave   bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             emit, idle_path, acc_clr, dig0, dig1, timeout;
    key_kind_t        kind_d, kind_q;
    logic [7:0]       code_d, code_q, b;
    logic             key_valid_q;

    assign b       = bus.rx_data;
    assign timeout = (cnt_q == CNT_W'(ESC_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            key_valid_q <= 1'b0;
            kind_q      <= KIND_ASCII;
            code_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            key_valid_q <= emit;
            if (emit) begin
                kind_q <= kind_d;
                code_q <= code_d;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        emit      = 1'b0;
        idle_path = 1'b0;
        kind_d    = KIND_ASCII;
        code_d    = b;
        acc_clr   = 1'b0;
        dig0      = 1'b0;
        dig1      = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bus.rx_valid ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: idle_path = bus.rx_valid;
            ST_ESC: begin
                if (bus.rx_valid) begin
                    if (b == BYTE_CSI) begin
                        state_d = ST_CSI;
                    end else if (b == BYTE_SS3) begin
                        state_d = ST_SS3;
                    end else if (b == BYTE_ESC) begin
                        emit    = 1'b1;
                        kind_d  = KIND_ESC;
                        acc_clr = 1'b1;
                        idx_d   = 2'd0;
                    end else begin
                        emit    = 1'b1;
                        kind_d  = KIND_META;
                        state_d = ST_IDLE;
                    end
                end else if (timeout) begin
                    emit    = 1'b1;
                    kind_d  = KIND_ESC;
                    code_d  = BYTE_ESC;
                    state_d = ST_IDLE;
                end
            end
            ST_SS3: begin
                if (bus.rx_valid) begin
                    emit    = 1'b1;
                    kind_d  = is_arrow(b) ? arrow_kind(b[2:0]) : KIND_CSI_OTHER;
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    emit    = 1'b1;
                    kind_d  = KIND_CSI_OTHER;
                    code_d  = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_CSI: begin
                if (bus.rx_valid) begin
                    if (is_digit(b)) begin
                        dig0 = (idx_q == 2'd0);
                        dig1 = (idx_q == 2'd1);
                    end else if (b == BYTE_SEP) begin
                        idx_d = (idx_q == 2'd2) ? 2'd2 : idx_q + 2'd1;
                    end else if (is_final(b)) begin
                        emit    = 1'b1;
                        kind_d  = is_arrow(b) ? arrow_kind(b[2:0]) : KIND_CSI_OTHER;
                        state_d = ST_IDLE;
                    end else begin
                        idle_path = 1'b1;
                    end
                end else if (timeout) begin
                    emit    = 1'b1;
                    kind_d  = KIND_CSI_OTHER;
                    code_d  = 8'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // shared by IDLE and by a CSI abort, which replays the byte as if idle
        if (idle_path) begin
            if (b == BYTE_ESC) begin
                state_d = ST_ESC;
                acc_clr = 1'b1;
                idx_d   = 2'd0;
            end else begin
                emit    = 1'b1;
                kind_d  = KIND_ASCII;
                state_d = ST_IDLE;
            end
        end

        if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end
    end

    dec_accum u_p0 (
        .clk         (clk),
        .rst         (rst),
        .clr         (acc_clr),
        .digit_valid (dig0),
        .digit       (b[3:0]),
        .value       (bus.csi_p0)
    );

    dec_accum u_p1 (
        .clk         (clk),
        .rst         (rst),
        .clr         (acc_clr),
        .digit_valid (dig1),
        .digit       (b[3:0]),
        .value       (bus.csi_p1)
    );

    assign bus.key_valid = key_valid_q;
    assign bus.key_kind  = kind_q;
    assign bus.key_code  = code_q;
endmodule

// File: tb/tb_ansi_key_decoder.sv
// tb/tb_ansi_key_decoder.sv - randomized and directed bench against a sequence-level key model
module tb_ansi_key_decoder;
    import ansi_pkg::*;

    localparam int TO = 100;

    typedef struct {
        int cyc;
        int kind;
        int code;
        int p0;
        int p1;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ansi_key_decoder_if bus ();

    ansi_key_decoder #(.ESC_TIMEOUT(TO), .CNT_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ev_t        expq[$];
    logic [7:0] pend[$];
    int checks = 0, failures = 0, cyc = 0, last_edge = 0;
    int cur_p0 = 0, cur_p1 = 0, last_kind = 0, last_code = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void push_ev(input int at, input int kind, input int code);
        ev_t e;
        e.cyc = at; e.kind = kind; e.code = code; e.p0 = cur_p0; e.p1 = cur_p1;
        expq.push_back(e);
    endfunction

    // Recompute both CSI parameters from the text collected after "ESC ["
    function automatic void parse_params();
        int p[2];
        int idx;
        p[0] = 0; p[1] = 0; idx = 0;
        for (int i = 2; i < pend.size(); i++) begin
            if (pend[i] == 8'h3B) idx++;
            else if (idx < 2) begin
                p[idx] = p[idx] * 10 + (int'(pend[i]) - 48);
                if (p[idx] > 255) p[idx] = 255;
            end
        end
        cur_p0 = p[0]; cur_p1 = p[1];
    endfunction

    function automatic int final_kind(input logic [7:0] b);
        case (b)
            8'h41: return 1;
            8'h42: return 2;
            8'h43: return 3;
            8'h44: return 4;
            default: return 7;
        endcase
    endfunction

    function automatic void idle_byte(input logic [7:0] b, input int at);
        if (b == 8'h1B) begin
            pend.push_back(b);
            cur_p0 = 0; cur_p1 = 0;
        end else begin
            push_ev(at, 0, b);
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int at);
        if (pend.size() == 0) begin
            idle_byte(b, at);
        end else if (pend.size() == 1) begin
            if (b == 8'h5B || b == 8'h4F) pend.push_back(b);
            else if (b == 8'h1B) begin
                cur_p0 = 0; cur_p1 = 0;
                push_ev(at, 5, 8'h1B);
            end else begin
                push_ev(at, 6, b);
                pend.delete();
            end
        end else if (pend[1] == 8'h4F) begin
            push_ev(at, final_kind(b), b);
            pend.delete();
        end else if ((b >= 8'h30 && b <= 8'h39) || b == 8'h3B) begin
            pend.push_back(b);
            parse_params();
        end else if (b >= 8'h40 && b <= 8'h7E) begin
            push_ev(at, final_kind(b), b);
            pend.delete();
        end else begin
            pend.delete();
            idle_byte(b, at);
        end
    endfunction

    function automatic void model_timeout(input int at);
        if (pend.size() == 1) push_ev(at, 5, 8'h1B);
        else push_ev(at, 7, 0);
        pend.delete();
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        int edge_n;
        edge_n = cyc + gap + 1;
        if (pend.size() != 0 && last_edge + TO < edge_n) model_timeout(last_edge + TO);
        repeat (gap) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        model_byte(b, edge_n);
        last_edge = edge_n;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        if (pend.size() != 0 && last_edge + TO <= cyc + n) model_timeout(last_edge + TO);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i], 10);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pend.delete();
        expq.delete();
        cur_p0 = 0; cur_p1 = 0; last_kind = 0; last_code = 0;
        check_eq("rst_valid", bus.key_valid, 0);
        check_eq("rst_kind", bus.key_kind, 0);
        check_eq("rst_code", bus.key_code, 0);
        check_eq("rst_p0", bus.csi_p0, 0);
        check_eq("rst_p1", bus.csi_p1, 0);
        mon_en = 1'b1;
    endtask

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (expq.size() != 0 && expq[0].cyc == cyc) begin
                    e = expq.pop_front();
                    check_eq("ev_valid", bus.key_valid, 1);
                    check_eq("ev_kind", bus.key_kind, e.kind);
                    check_eq("ev_code", bus.key_code, e.code);
                    check_eq("ev_p0", bus.csi_p0, e.p0);
                    check_eq("ev_p1", bus.csi_p1, e.p1);
                    last_kind = e.kind;
                    last_code = e.code;
                end else begin
                    check_eq("no_pulse", bus.key_valid, 0);
                    check_eq("hold_kind", bus.key_kind, last_kind);
                    check_eq("hold_code", bus.key_code, last_code);
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int g;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        do_reset();

        send(8'h71, 10);
        send_seq('{8'h1B, 8'h5B, 8'h41});
        send_seq('{8'h1B, 8'h4F, 8'h44});
        send_seq('{8'h1B, 8'h5B, 8'h31, 8'h32, 8'h3B, 8'h34, 8'h30, BYTE_CPR});
        send(8'h1B, 10);
        settle(TO + 20);
        send_seq('{8'h1B, 8'h71});
        send_seq('{8'h1B, 8'h5B, 8'h39, 8'h39, 8'h39, 8'h3B, 8'h3B, 8'h37, 8'h41});
        send_seq('{8'h1B, 8'h5B, 8'h0D});
        send_seq('{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h35, 8'h41});
        send_seq('{8'h1B, 8'h1B, 8'h41});
        send_seq('{8'h1B, 8'h5B});
        do_reset();
        send(8'h41, 10);
        send(8'h1B, 10);
        send(8'h5B, TO - 1);
        send(8'h43, TO - 1);
        send(8'h1B, 10);
        send(8'h5B, TO);
        send_seq('{8'h1B, 8'h5B, 8'h33});
        settle(TO + 20);
        send_seq('{8'h1B, 8'h4F});
        settle(TO + 20);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = 8'h1B;
                2:       b = 8'h5B;
                3:       b = 8'h4F;
                4, 5:    b = 8'(8'h30 + $urandom_range(0, 9));
                6:       b = 8'h3B;
                7:       b = 8'(8'h41 + $urandom_range(0, 3));
                8:       b = 8'h52;
                default: b = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 19))
                0:       g = TO - 1;
                1:       g = TO;
                default: g = 10 + int'($urandom_range(0, 10));
            endcase
            send(b, g);
        end
        settle(TO + 20);
        check_eq("drain", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
